regfile_scoreboard: RTL and testbench

- 32 x 32-bit RISC-V integer register file: the consuming end of the write-back stage.
- Accepts the write-back data and destination index, and serves two combinational read ports to decode, with same-cycle write-to-read bypass.
- Tracks in-flight writers per register with a scoreboard.
- Raises a stall to decode when a source or destination register is not yet safe to use.

---
 rtl/regfile_scoreboard.sv | 105 ++++++++++
 tb/tb_regfile_scoreboard.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// RISC-V integer register file with write-back bypass and a per-register
// in-flight writer scoreboard that stalls decode on RAW and writer-saturation hazards.
module regfile_scoreboard #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_write_from_wb,
  input  logic [4:0]  immed_11_7_from_wb,
  input  logic        reg_write_from_wb,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic        issue_valid,
  input  logic        issue_writes,
  input  logic [4:0]  issue_rd,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        hazard_stall,
  output logic        wb_underflow_err
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] regs_q [NREGS];
  cnt_t        cnt_q  [NREGS];
  cnt_t        cnt_d  [NREGS];
  logic        err_q, err_d;

  logic wb_en;
  logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic src1_haz, src2_haz, dst_haz;
  logic issue_inc;
  cnt_t cnt_rs1, cnt_rs2, cnt_rd;

  assign wb_en      = reg_write_from_wb && (immed_11_7_from_wb != 5'd0);
  assign wb_hit_rs1 = wb_en && (immed_11_7_from_wb == rs1_addr);
  assign wb_hit_rs2 = wb_en && (immed_11_7_from_wb == rs2_addr);
  assign wb_hit_rd  = wb_en && (immed_11_7_from_wb == issue_rd);

  assign cnt_rs1 = cnt_q[rs1_addr];
  assign cnt_rs2 = cnt_q[rs2_addr];
  assign cnt_rd  = cnt_q[issue_rd];

  // Reads are forced to zero while reset is held so bypass cannot leak through.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rst && (rs1_addr != 5'd0)) begin
      rs1_data = wb_hit_rs1 ? data_write_from_wb : regs_q[rs1_addr];
    end
    if (rst && (rs2_addr != 5'd0)) begin
      rs2_data = wb_hit_rs2 ? data_write_from_wb : regs_q[rs2_addr];
    end
  end

  // A single outstanding writer that lands this cycle is covered by the bypass.
  always_comb begin
    src1_haz = rs1_used && (rs1_addr != 5'd0) &&
               ((32'(cnt_rs1) >= 32'd2) || ((32'(cnt_rs1) == 32'd1) && !wb_hit_rs1));
    src2_haz = rs2_used && (rs2_addr != 5'd0) &&
               ((32'(cnt_rs2) >= 32'd2) || ((32'(cnt_rs2) == 32'd1) && !wb_hit_rs2));
    dst_haz  = issue_writes && (issue_rd != 5'd0) &&
               (32'(cnt_rd) == MAX_INFLIGHT) && !wb_hit_rd;
  end

  assign hazard_stall = rst && issue_valid && (src1_haz || src2_haz || dst_haz);
  assign issue_inc    = issue_valid && !hazard_stall && issue_writes && (issue_rd != 5'd0);

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if ((issue_inc && (issue_rd == 5'(r))) &&
          !(wb_en && (immed_11_7_from_wb == 5'(r)) && (cnt_q[r] != '0))) begin
        cnt_d[r] = cnt_q[r] + cnt_t'(1);
      end else if (!(issue_inc && (issue_rd == 5'(r))) &&
                   (wb_en && (immed_11_7_from_wb == 5'(r)) && (cnt_q[r] != '0))) begin
        cnt_d[r] = cnt_q[r] - cnt_t'(1);
      end
    end
    err_d = err_q || (wb_en && (cnt_q[immed_11_7_from_wb] == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (wb_en) begin
        regs_q[immed_11_7_from_wb] <= data_write_from_wb;
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign wb_underflow_err = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random
// traffic, all compared against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int unsigned MAXI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_write_from_wb;
  logic [4:0]  immed_11_7_from_wb;
  logic        reg_write_from_wb;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_used, rs2_used;
  logic        issue_valid, issue_writes;
  logic [4:0]  issue_rd;
  logic [31:0] rs1_data, rs2_data;
  logic        hazard_stall, wb_underflow_err;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_reg [32];
  int unsigned m_cnt [32];
  bit          m_err;
  logic [31:0] e_rs1, e_rs2;
  logic        e_stall;

  regfile_scoreboard #(.NREGS(32), .MAX_INFLIGHT(MAXI)) dut (
    .clk                (clk),
    .rst                (rst),
    .data_write_from_wb (data_write_from_wb),
    .immed_11_7_from_wb (immed_11_7_from_wb),
    .reg_write_from_wb  (reg_write_from_wb),
    .rs1_addr           (rs1_addr),
    .rs2_addr           (rs2_addr),
    .rs1_used           (rs1_used),
    .rs2_used           (rs2_used),
    .issue_valid        (issue_valid),
    .issue_writes       (issue_writes),
    .issue_rd           (issue_rd),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .hazard_stall       (hazard_stall),
    .wb_underflow_err   (wb_underflow_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (reg_write_from_wb && immed_11_7_from_wb == a) return data_write_from_wb;
    return m_reg[a];
  endfunction

  function automatic bit m_src_haz(logic used, logic [4:0] a);
    bit landing = reg_write_from_wb && (immed_11_7_from_wb == a);
    return used && (a != 5'd0) && ((m_cnt[a] >= 2) || (m_cnt[a] == 1 && !landing));
  endfunction

  function automatic void model_eval();
    bit dst;
    e_rs1   = m_read(rs1_addr);
    e_rs2   = m_read(rs2_addr);
    dst     = issue_writes && (issue_rd != 5'd0) && (m_cnt[issue_rd] == MAXI) &&
              !(reg_write_from_wb && immed_11_7_from_wb == issue_rd);
    e_stall = issue_valid && (m_src_haz(rs1_used, rs1_addr) ||
                              m_src_haz(rs2_used, rs2_addr) || dst);
  endfunction

  // Evaluate the model on the pre-edge inputs, clock, then retire the model's state.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (reg_write_from_wb && immed_11_7_from_wb != 5'd0) begin
      if (m_cnt[immed_11_7_from_wb] == 0) m_err = 1'b1;
      else m_cnt[immed_11_7_from_wb]--;
      m_reg[immed_11_7_from_wb] = data_write_from_wb;
    end
    if (issue_valid && !e_stall && issue_writes && issue_rd != 5'd0) m_cnt[issue_rd]++;
    #1;
  endtask

  task automatic drive_idle();
    data_write_from_wb = '0;
    immed_11_7_from_wb = '0;
    reg_write_from_wb  = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    issue_valid  = 1'b0;
    issue_writes = 1'b0;
    issue_rd     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    #12;
    model_reset();
    n_total++;
    if (rs1_data !== 32'd0) $display("FAIL reset_rs1: got %h want 0", rs1_data); else n_pass++;
    n_total++;
    if (rs2_data !== 32'd0) $display("FAIL reset_rs2: got %h want 0", rs2_data); else n_pass++;
    n_total++;
    if (hazard_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", hazard_stall);
    else n_pass++;
    n_total++;
    if (wb_underflow_err !== 1'b0) $display("FAIL reset_err: got %b want 0", wb_underflow_err);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_x0();
    drive_idle();
    reg_write_from_wb  = 1'b1;
    immed_11_7_from_wb = 5'd0;
    data_write_from_wb = 32'h12345678;
    #1;
    n_total++;
    if (rs1_data !== 32'd0) $display("FAIL x0_bypass: got %h want 0", rs1_data); else n_pass++;
    tick();
    drive_idle();
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_rd     = 5'd0;
    rs1_used     = 1'b1;
    #1;
    n_total++;
    if (rs1_data !== 32'd0) $display("FAIL x0_read: got %h want 0", rs1_data); else n_pass++;
    n_total++;
    if (hazard_stall !== 1'b0) $display("FAIL x0_issue_stall: got %b want 0", hazard_stall);
    else n_pass++;
    tick();
    n_total++;
    if (wb_underflow_err !== 1'b0) $display("FAIL x0_err: got %b want 0", wb_underflow_err);
    else n_pass++;
  endtask

  task automatic test_raw_stall();
    drive_idle();
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_rd     = 5'd3;
    #1;
    n_total++;
    if (hazard_stall !== 1'b0) $display("FAIL raw_first_issue: got %b want 0", hazard_stall);
    else n_pass++;
    tick();
    drive_idle();
    issue_valid = 1'b1;
    rs2_used    = 1'b1;
    rs2_addr    = 5'd3;
    #1;
    n_total++;
    if (hazard_stall !== 1'b1) $display("FAIL raw_stall: got %b want 1", hazard_stall);
    else n_pass++;
    tick();
    reg_write_from_wb  = 1'b1;
    immed_11_7_from_wb = 5'd3;
    data_write_from_wb = 32'h55;
    #1;
    n_total++;
    if (hazard_stall !== 1'b0) $display("FAIL raw_release: got %b want 0", hazard_stall);
    else n_pass++;
    n_total++;
    if (rs2_data !== 32'h55) $display("FAIL raw_bypass: got %h want 00000055", rs2_data);
    else n_pass++;
    tick();
    drive_idle();
    rs2_addr = 5'd3;
    #1;
    n_total++;
    if (rs2_data !== 32'h55) $display("FAIL raw_stored: got %h want 00000055", rs2_data);
    else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    drive_idle();
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_rd     = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (hazard_stall !== 1'b0) $display("FAIL sat_issue%0d: got %b want 0", i, hazard_stall);
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if (hazard_stall !== 1'b1) $display("FAIL sat_full: got %b want 1", hazard_stall);
    else n_pass++;
    tick();
    reg_write_from_wb  = 1'b1;
    immed_11_7_from_wb = 5'd9;
    data_write_from_wb = 32'hA5A5_0009;
    #1;
    n_total++;
    if (hazard_stall !== 1'b0) $display("FAIL sat_wb_accept: got %b want 0", hazard_stall);
    else n_pass++;
    tick();
    reg_write_from_wb = 1'b0;
    #1;
    n_total++;
    if (hazard_stall !== 1'b1) $display("FAIL sat_still_full: got %b want 1", hazard_stall);
    else n_pass++;
    tick();
    // Drain the three outstanding writers of x9.
    drive_idle();
    reg_write_from_wb  = 1'b1;
    immed_11_7_from_wb = 5'd9;
    for (int i = 0; i < 3; i++) begin
      data_write_from_wb = 32'h900 + 32'(i);
      tick();
    end
    drive_idle();
    issue_valid = 1'b1;
    rs1_used    = 1'b1;
    rs1_addr    = 5'd9;
    #1;
    n_total++;
    if (hazard_stall !== 1'b0) $display("FAIL sat_drained: got %b want 0", hazard_stall);
    else n_pass++;
    n_total++;
    if (wb_underflow_err !== 1'b0) $display("FAIL sat_err: got %b want 0", wb_underflow_err);
    else n_pass++;
    tick();
  endtask

  task automatic test_underflow();
    do_reset();
    drive_idle();
    reg_write_from_wb  = 1'b1;
    immed_11_7_from_wb = 5'd12;
    data_write_from_wb = 32'hC0FF_EE12;
    rs1_addr = 5'd12;
    #1;
    n_total++;
    if (wb_underflow_err !== 1'b0) $display("FAIL uf_before: got %b want 0", wb_underflow_err);
    else n_pass++;
    tick();
    drive_idle();
    rs1_addr = 5'd12;
    #1;
    n_total++;
    if (wb_underflow_err !== 1'b1) $display("FAIL uf_set: got %b want 1", wb_underflow_err);
    else n_pass++;
    n_total++;
    if (rs1_data !== 32'hC0FF_EE12) $display("FAIL uf_data: got %h want c0ffee12", rs1_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    n_total++;
    if (wb_underflow_err !== 1'b1) $display("FAIL uf_sticky: got %b want 1", wb_underflow_err);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    drive_idle();
    reg_write_from_wb  = 1'b1;
    immed_11_7_from_wb = 5'd5;
    data_write_from_wb = 32'hAA;
    tick();
    drive_idle();
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_rd     = 5'd5;
    tick();
    tick();
    drive_idle();
    issue_valid = 1'b1;
    rs1_used    = 1'b1;
    rs1_addr    = 5'd5;
    #1;
    n_total++;
    if (hazard_stall !== 1'b1) $display("FAIL mid_pre_stall: got %b want 1", hazard_stall);
    else n_pass++;
    rst = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (rs1_data !== 32'd0) $display("FAIL mid_rs1: got %h want 0", rs1_data); else n_pass++;
    n_total++;
    if (hazard_stall !== 1'b0) $display("FAIL mid_stall: got %b want 0", hazard_stall);
    else n_pass++;
    n_total++;
    if (wb_underflow_err !== 1'b0) $display("FAIL mid_err: got %b want 0", wb_underflow_err);
    else n_pass++;
    rst = 1'b1;
    tick();
    #1;
    n_total++;
    if (hazard_stall !== 1'b0) $display("FAIL mid_after_release: got %b want 0", hazard_stall);
    else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    drive_idle();
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_rd     = 5'd7;
    tick();
    drive_idle();
    reg_write_from_wb  = 1'b1;
    immed_11_7_from_wb = 5'd7;
    data_write_from_wb = 32'hDEAD_BEEF;
    rs1_addr = 5'd7;
    #1;
    n_total++;
    if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL byp_same: got %h want deadbeef", rs1_data);
    else n_pass++;
    tick();
    reg_write_from_wb = 1'b0;
    #1;
    n_total++;
    if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL byp_next: got %h want deadbeef", rs1_data);
    else n_pass++;
    n_total++;
    if (wb_underflow_err !== 1'b0) $display("FAIL byp_err: got %b want 0", wb_underflow_err);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reg_write_from_wb  = ($urandom_range(0, 9) < 4);
      immed_11_7_from_wb = 5'($urandom_range(0, 7));
      data_write_from_wb = $urandom;
      rs1_addr     = 5'($urandom_range(0, 7));
      rs2_addr     = 5'($urandom_range(0, 7));
      rs1_used     = 1'($urandom_range(0, 1));
      rs2_used     = 1'($urandom_range(0, 1));
      issue_valid  = ($urandom_range(0, 9) < 8);
      issue_writes = ($urandom_range(0, 9) < 7);
      issue_rd     = 5'($urandom_range(0, 7));
      #1;
      model_eval();
      n_total++;
      if (rs1_data !== e_rs1) $display("FAIL rnd_rs1 @%0d: got %h want %h", i, rs1_data, e_rs1);
      else n_pass++;
      n_total++;
      if (rs2_data !== e_rs2) $display("FAIL rnd_rs2 @%0d: got %h want %h", i, rs2_data, e_rs2);
      else n_pass++;
      n_total++;
      if (hazard_stall !== e_stall)
        $display("FAIL rnd_stall @%0d: got %b want %b", i, hazard_stall, e_stall);
      else n_pass++;
      n_total++;
      if (wb_underflow_err !== m_err)
        $display("FAIL rnd_err @%0d: got %b want %b", i, wb_underflow_err, m_err);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_raw_stall();
    test_saturation();
    test_underflow();
    test_reset_midrun();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
